// File: rtl/instr_prefetch_pkg.sv
// Shared types and default widths for the instruction prefetch stage.
package instr_prefetch_pkg;

    localparam int unsigned PF_ADDR_W = 16;
    localparam int unsigned PF_DATA_W = 32;

    // Memory-side request tracker states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding
        BUSY = 2'd1,  // request outstanding, data is wanted
        DROP = 2'd2   // request outstanding, data will be discarded
    } pf_state_e;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Circular word store for the prefetch queue: push at tail, pop at head,
// combinational peek of the two oldest entries, and a one-cycle clear.
module prefetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = PF_DATA_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] peek0_o,
    output logic [DATA_W-1:0] peek1_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  count_next_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_p1;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    // Pointer/occupancy update; a push is accepted when not full or when a pop frees a slot.
    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers: pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage; never reset, validity is tracked by the occupancy count.
    always_ff @(posedge clock) begin
        if (push_ok && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign rd_ptr_p1    = rd_ptr_q + PTR_W'(1);
    assign peek0_o      = mem_q[rd_ptr_q];
    assign peek1_o      = mem_q[rd_ptr_p1];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage in front of the core. Fetches sequential words
// from a variable-latency memory (req/ack, one outstanding request) into a
// small queue and serves the core's instrAddr with a zero-latency hit path.
// Any non-sequential instrAddr flushes the queue and refetches.
// Optional: define INSTR_PREFETCH_PERF_EN to add redirectCount/stallCount.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned       DEPTH      = 4,
    parameter int unsigned       ADDR_W     = PF_ADDR_W,
    parameter int unsigned       DATA_W     = PF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] instrAddr,
    output logic [DATA_W-1:0] instruction,
    output logic              instrValid,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memData
`ifdef INSTR_PREFETCH_PERF_EN
    ,
    output logic [15:0]       redirectCount,
    output logic [15:0]       stallCount
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    pf_state_e         fsm_q, fsm_d;
    logic [ADDR_W-1:0] headAddr_q, headAddr_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              memReq_q, memReq_d;

    logic [CNT_W-1:0]  count, count_next;
    logic [DATA_W-1:0] peek0, peek1;
    logic [ADDR_W-1:0] head_plus1;
    logic [ADDR_W-1:0] fetch_next;
    logic              hit0, hit1;
    logic              is_seq, is_wait, redirect;
    logic              push, pop;
    logic              room_next;

    prefetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .data_i       (memData),
        .pop_i        (pop),
        .clear_i      (redirect),
        .peek0_o      (peek0),
        .peek1_o      (peek1),
        .count_o      (count),
        .count_next_o (count_next)
    );

    // Lookup and per-cycle classification of the core's address against the queue head.
    always_comb begin
        head_plus1  = headAddr_q + ADDR_W'(1);
        hit0        = (count != '0) && (instrAddr == headAddr_q);
        hit1        = (count >= CNT_W'(2)) && (instrAddr == head_plus1);
        instrValid  = hit0 || hit1;
        instruction = hit0 ? peek0 : peek1;
        is_seq      = (count != '0) && (instrAddr == head_plus1);
        is_wait     = (instrAddr == headAddr_q);
        redirect    = !is_seq && !is_wait;
        pop         = is_seq;
        push        = (fsm_q == BUSY) && memAck && !redirect;
        headAddr_d  = redirect ? instrAddr : (pop ? head_plus1 : headAddr_q);
        // headAddr+count is the next word not yet fetched, after this edge's push/pop/flush.
        fetch_next  = headAddr_d + ADDR_W'(count_next);
        room_next   = count_next < CNT_W'(DEPTH);
    end

    // Request tracker: issue while there is room, keep one request outstanding,
    // and discard data of a request that a redirect has made stale.
    always_comb begin
        fsm_d     = fsm_q;
        memReq_d  = memReq_q;
        memAddr_d = memAddr_q;
        case (fsm_q)
            IDLE: begin
                // Late acks from an abandoned request land here and are ignored.
                if (room_next) begin
                    fsm_d     = BUSY;
                    memReq_d  = 1'b1;
                    memAddr_d = fetch_next;
                end
            end
            BUSY: begin
                if (redirect) begin
                    if (memAck) begin
                        // Stale word dropped; restart at the new target immediately.
                        memAddr_d = fetch_next;
                    end else begin
                        // Address must stay stable until the memory answers.
                        fsm_d = DROP;
                    end
                end else if (memAck) begin
                    if (room_next) begin
                        memAddr_d = fetch_next;
                    end else begin
                        fsm_d    = IDLE;
                        memReq_d = 1'b0;
                    end
                end
            end
            DROP: begin
                // Queue is empty here, so fetch_next is the latest redirect target.
                if (memAck) begin
                    fsm_d     = BUSY;
                    memAddr_d = fetch_next;
                end
            end
            default: begin
                fsm_d    = IDLE;
                memReq_d = 1'b0;
            end
        endcase
    end

    // State, head address and registered memory request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q      <= IDLE;
            headAddr_q <= RESET_ADDR;
            memReq_q   <= 1'b0;
            memAddr_q  <= '0;
        end else begin
            fsm_q      <= fsm_d;
            headAddr_q <= headAddr_d;
            memReq_q   <= memReq_d;
            memAddr_q  <= memAddr_d;
        end
    end

    assign memReq  = memReq_q;
    assign memAddr = memAddr_q;

`ifdef INSTR_PREFETCH_PERF_EN
    logic [15:0] redirectCount_q, redirectCount_d;
    logic [15:0] stallCount_q, stallCount_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating event counters.
    always_comb begin
        redirectCount_d = redirect ? sat_inc16(redirectCount_q) : redirectCount_q;
        stallCount_d    = instrValid ? stallCount_q : sat_inc16(stallCount_q);
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirectCount_q <= '0;
            stallCount_q    <= '0;
        end else begin
            redirectCount_q <= redirectCount_d;
            stallCount_q    <= stallCount_d;
        end
    end

    assign redirectCount = redirectCount_q;
    assign stallCount    = stallCount_q;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: behavioural memory with programmable latency,
// a simple core model, and scoreboards for returned words and request addresses.
module tb_instr_prefetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instrAddr;
    logic [31:0] instruction;
    logic        instrValid;
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
`ifdef INSTR_PREFETCH_PERF_EN
    logic [15:0] redirectCount;
    logic [15:0] stallCount;
`endif

    instr_prefetch #(
        .DEPTH      (4),
        .ADDR_W     (16),
        .DATA_W     (32),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instrAddr   (instrAddr),
        .instruction (instruction),
        .instrValid  (instrValid),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memAck      (memAck),
        .memData     (memData)
`ifdef INSTR_PREFETCH_PERF_EN
        ,
        .redirectCount (redirectCount),
        .stallCount    (stallCount)
`endif
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [15:0] addr_q[$];
    int          lat = 0;
    int          age = 0;
    bit          newreq = 1'b1;
    bit          run = 1'b0;
    bit          adv = 1'b0;
    int          valid_cnt = 0;
    int          invalid_cnt = 0;
    int          ack_cnt = 0;
    int          req_cnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_addr = '0;
    bit          found;
`ifdef INSTR_PREFETCH_PERF_EN
    logic [15:0] rc0;
`endif

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Core jumps to a new address; anything expected before is forgotten.
    task automatic set_addr(input logic [15:0] a);
        instrAddr = a;
        exp_q.delete();
        exp_q.push_back(mem_word(a));
        adv = 1'b0;
    endtask

    // Core moves to the next sequential address.
    task automatic core_next();
        instrAddr = instrAddr + 16'd1;
        exp_q.delete(0);
        exp_q.push_back(mem_word(instrAddr));
    endtask

    // One clock: core advance and memory response after the edge, checks at the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (adv) begin
            core_next();
            adv = 1'b0;
        end
        if (memReq) begin
            if (newreq) age = 0;
            else age++;
            memAck  = (age >= lat);
            memData = memAck ? mem_word(memAddr) : $urandom;
            newreq  = memAck;
        end else begin
            memAck  = 1'b0;
            memData = $urandom;
            newreq  = 1'b1;
        end
        @(negedge clock);
        if (instrValid) begin
            valid_cnt++;
            chk("data", instruction, exp_q[0]);
            if (run) adv = 1'b1;
        end else begin
            invalid_cnt++;
        end
        if (memReq) req_cnt++;
        if (memReq && memAck) begin
            ack_cnt++;
            if (addr_q.size() > 0) chk("mem_addr", 32'(memAddr), 32'(addr_q.pop_front()));
        end
        if (memReq && prev_req && !prev_ack) chk("addr_hold", 32'(memAddr), 32'(prev_addr));
        prev_req  = memReq;
        prev_ack  = memAck;
        prev_addr = memAddr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        memAck  = 1'b0;
        memData = '0;
        set_addr(16'h0000);
        repeat (2) @(negedge clock);
        chk("rst_req", 32'(memReq), 32'd0);
        chk("rst_addr", 32'(memAddr), 32'd0);
        chk("rst_valid", 32'(instrValid), 32'd0);

        // Sequential stream with single-cycle memory.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) addr_q.push_back(16'(i));
        lat = 0;
        run = 1'b1;
        valid_cnt = 0;
        repeat (12) tick();
        chk("seq_valid_cycles", 32'(valid_cnt), 32'd11);
        chk("seq_core_addr", 32'(instrAddr), 32'd10);
        chk("seq_reqs_seen", 32'(addr_q.size()), 32'd0);

        // Core holds one address: queue fills and requests stop.
        run = 1'b0;
        set_addr(16'd5);
        addr_q.delete();
        for (int i = 5; i < 9; i++) addr_q.push_back(16'(i));
        ack_cnt = 0;
        repeat (8) tick();
        chk("hold_reqs", 32'(ack_cnt), 32'd4);
        chk("hold_req_low", 32'(memReq), 32'd0);
        chk("hold_valid", 32'(instrValid), 32'd1);
        req_cnt = 0;
        repeat (4) tick();
        chk("idle_no_req", 32'(req_cnt), 32'd0);
        core_next();
        addr_q.push_back(16'd9);
        ack_cnt = 0;
        repeat (4) tick();
        chk("refill_reqs", 32'(ack_cnt), 32'd1);
        chk("refill_idle", 32'(memReq), 32'd0);
        chk("refill_addrs", 32'(addr_q.size()), 32'd0);

        // Redirect while a slow request is outstanding.
        lat = 3;
        set_addr(16'h0000);
        addr_q.delete();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (memReq && memAddr == 16'd3 && !memAck) found = 1'b1;
        end
        chk("reach_req3", 32'(found), 32'd1);
        set_addr(16'h0040);
        addr_q.push_back(16'd3);
        addr_q.push_back(16'h0040);
        valid_cnt = 0;
        tick();
        chk("drop_hold_addr", 32'(memAddr), 32'd3);
        chk("drop_no_valid", 32'(instrValid), 32'd0);
        repeat (15) tick();
        chk("drop_acks_done", 32'(addr_q.size()), 32'd0);
        chk("redirect_valid_seen", 32'(valid_cnt > 0), 32'd1);

        // Redirect in the same cycle as an ack.
        lat = 1;
        set_addr(16'h0070);
        addr_q.delete();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (memReq && memAck && memAddr == 16'h0070) found = 1'b1;
        end
        chk("reach_ack70", 32'(found), 32'd1);
        set_addr(16'h0080);
        addr_q.push_back(16'h0080);
        tick();
        chk("same_cycle_addr", 32'(memAddr), 32'h0080);
        chk("same_cycle_req", 32'(memReq), 32'd1);
        repeat (6) tick();
        chk("same_cycle_acks", 32'(addr_q.size()), 32'd0);

        // Sequential fetch across the address wrap.
        lat = 0;
        repeat (6) tick();
`ifdef INSTR_PREFETCH_PERF_EN
        rc0 = redirectCount;
`endif
        set_addr(16'hFFFC);
        run = 1'b1;
        tick();
        tick();
        invalid_cnt = 0;
        repeat (12) tick();
        chk("wrap_no_stall", 32'(invalid_cnt), 32'd0);
        chk("wrap_core_addr", 32'(instrAddr), 32'h0008);
`ifdef INSTR_PREFETCH_PERF_EN
        chk("wrap_redirects", 32'(redirectCount), 32'(rc0 + 16'd1));
`endif

        // Reset while a request is outstanding; a late ack must be ignored.
        run = 1'b0;
        lat = 5;
        set_addr(16'h0200);
        tick();
        tick();
        chk("pre_reset_busy", 32'(memReq), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(memReq), 32'd0);
        chk("async_rst_addr", 32'(memAddr), 32'd0);
        chk("async_rst_valid", 32'(instrValid), 32'd0);
        memAck = 1'b0;
        set_addr(16'h0000);
        tick();
        tick();
        reset   = 1'b0;
        memAck  = 1'b1;
        memData = 32'hDEADBEEF;
        addr_q.delete();
        addr_q.push_back(16'h0000);
        lat = 0;
        valid_cnt = 0;
        repeat (6) tick();
        chk("post_rst_first_req", 32'(addr_q.size()), 32'd0);
        chk("post_rst_valid", 32'(valid_cnt > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
